// File: rtl/rr_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_select_arbiter
// Brief    : 8-way round-robin arbiter driving a 3-to-8 enable decoder.
//            Registered select/enable; grant held until done or request drop;
//            one idle cycle between owners. Optional forced release after
//            MAX_HOLD cycles when RR_SELECT_ARBITER_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rr_select_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] select,
    output logic       enable,
    output logic       timeout
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_select;
    logic [2:0] w_select_nxt;
    logic       r_enable;
    logic       w_enable_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    logic       w_found;
    logic [2:0] w_idx;
    logic       w_release;
    logic       w_hold_expired;

    // Normal release: owner signals done or withdraws its request.
    assign w_release = done | ~req[r_select];

`ifdef RR_SELECT_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    assign w_hold_expired = (r_cnt == CNT_W'(MAX_HOLD - 1));

    // Hold counter: cleared while idle so a new grant starts at zero,
    // counts each held cycle, never passes MAX_HOLD-1 (release fires there).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == c_IDLE) begin
            r_cnt <= '0;
        end else if (!w_release && !w_hold_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_hold_expired = 1'b0;
`endif

    // Priority search: first set request at ptr, ptr+1, ... ptr+7 (mod 8).
    // Walking downward lets the smallest offset win the last assignment.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (req[r_ptr + 3'(k)]) begin
                w_found = 1'b1;
                w_idx   = r_ptr + 3'(k);
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_select_nxt  = r_select;
        w_enable_nxt  = r_enable;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_enable_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt  = c_GRANT;
                    w_select_nxt = w_idx;
                    w_enable_nxt = 1'b1;
                    w_ptr_nxt    = w_idx + 3'd1;
                end
            end
            c_GRANT: begin
                if (w_release || w_hold_expired) begin
                    w_state_nxt   = c_IDLE;
                    w_enable_nxt  = 1'b0;
                    // A normal release in the same cycle is not a timeout.
                    w_timeout_nxt = w_hold_expired & ~w_release;
                end
            end
            default: begin
                w_state_nxt  = c_IDLE;
                w_enable_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_ptr     <= 3'd0;
            r_select  <= 3'd0;
            r_enable  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_select  <= w_select_nxt;
            r_enable  <= w_enable_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign select  = r_select;
    assign enable  = r_enable;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_select_arbiter
// Brief    : Self-checking bench for rr_select_arbiter: vector table,
//            hand-written hold/timeout sequences, randomized traffic against
//            a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_select_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef RR_SELECT_ARBITER_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] select;
    logic       enable;
    logic       timeout;

    rr_select_arbiter #(.MAX_HOLD(MAX_HOLD)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .select  (select),
        .enable  (enable),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner index (-1 = nobody), priority pointer, hold age.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_age   = 0;
    int m_sel   = 0;
    int m_tmo   = 0;

    function automatic void model_step(input logic r, input logic [7:0] q, input logic d);
        if (!r) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_sel = 0; m_tmo = 0;
        end else if (m_owner < 0) begin
            m_tmo = 0;
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && q[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
            end
            if (m_owner >= 0) begin
                m_sel = m_owner;
                m_ptr = (m_owner + 1) % 8;
                m_age = 0;
            end
        end else if (d || !q[m_owner]) begin
            m_owner = -1; m_tmo = 0;
        end else if (TMO_ON && m_age == MAX_HOLD - 1) begin
            m_owner = -1; m_tmo = 1;
        end else begin
            m_age = m_age + 1; m_tmo = 0;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs between edges, let the edge happen, sample later.
    task automatic cycle(input logic r, input logic [7:0] q, input logic d);
        rst_n = r; req = q; done = d;
        @(posedge clk);
        model_step(r, q, d);
        #1;
    endtask

    function automatic int onehot(input logic en, input logic [2:0] s);
        int v;
        v = en ? (1 << s) : 0;
        return v;
    endfunction

    typedef struct packed {
        logic       rst_n;
        logic [7:0] req;
        logic       done;
        logic       en;
        logic [2:0] sel;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [7:0] q, input logic d,
                                input logic e, input logic [2:0] s, input logic t);
        vec_t v;
        v.rst_n = r; v.req = q; v.done = d; v.en = e; v.sel = s; v.tmo = t;
        return v;
    endfunction

    initial begin
        logic [7:0] rq;
        logic       rd;
        logic       rr;
        rst_n = 1'b0; req = 8'h00; done = 1'b0;

        // Reset with all requesting, then idle.
        vecs.push_back(mk(0, 8'hFF, 0, 0, 3'd0, 0));
        vecs.push_back(mk(0, 8'hFF, 0, 0, 3'd0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 8'h00, 0, 0, 3'd0, 0));
        // Single request to 5, held, released with done; select holds.
        vecs.push_back(mk(1, 8'h20, 0, 1, 3'd5, 0));
        vecs.push_back(mk(1, 8'h20, 0, 1, 3'd5, 0));
        vecs.push_back(mk(1, 8'h20, 1, 0, 3'd5, 0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 3'd5, 0));
        // Re-reset, then all requesting: 0..7 then wrap to 0, bubble between.
        vecs.push_back(mk(0, 8'h00, 0, 0, 3'd0, 0));
        for (int g = 0; g < 9; g++) begin
            vecs.push_back(mk(1, 8'hFF, 0, 1, 3'(g % 8), 0));
            vecs.push_back(mk(1, 8'hFF, 1, 0, 3'(g % 8), 0));
        end
        // Grant 6, release, then {6,0}: search starts at 7 so 0 wins.
        vecs.push_back(mk(1, 8'h40, 0, 1, 3'd6, 0));
        vecs.push_back(mk(1, 8'h40, 1, 0, 3'd6, 0));
        vecs.push_back(mk(1, 8'h41, 0, 1, 3'd0, 0));
        vecs.push_back(mk(1, 8'h41, 1, 0, 3'd0, 0));
        // Grant 3, drop its request without done: release, no timeout.
        vecs.push_back(mk(1, 8'h08, 0, 1, 3'd3, 0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 3'd3, 0));
        // Done in IDLE is ignored; then grant 3 and reset mid-grant with done.
        vecs.push_back(mk(1, 8'h00, 1, 0, 3'd3, 0));
        vecs.push_back(mk(1, 8'h08, 0, 1, 3'd3, 0));
        vecs.push_back(mk(0, 8'h08, 1, 0, 3'd0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 1, 3'd0, 0));
        vecs.push_back(mk(1, 8'h01, 1, 0, 3'd0, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d enable", i), int'(enable), int'(vecs[i].en));
            check($sformatf("vec%0d select", i), int'(select), int'(vecs[i].sel));
            check($sformatf("vec%0d timeout", i), int'(timeout), int'(vecs[i].tmo));
            check($sformatf("vec%0d decode", i), onehot(enable, select),
                  vecs[i].en ? (1 << vecs[i].sel) : 0);
        end

        // Hold sequence: requester 2 holds with no done, 4 also pending.
        cycle(0, 8'h00, 0);
        cycle(1, 8'h14, 0);
        check("hold first enable", int'(enable), 1);
        check("hold first select", int'(select), 2);
`ifdef RR_SELECT_ARBITER_TIMEOUT_EN
        for (int c = 2; c <= 4; c++) begin
            cycle(1, 8'h14, 0);
            check("hold enable", int'(enable), 1);
            check("hold timeout", int'(timeout), 0);
        end
        cycle(1, 8'h14, 0);
        check("timeout enable falls", int'(enable), 0);
        check("timeout pulse", int'(timeout), 1);
        cycle(1, 8'h14, 0);
        check("after timeout pulse", int'(timeout), 0);
        check("after timeout select", int'(select), 4);
        check("after timeout enable", int'(enable), 1);
        // done coincident with expiry: plain release, no pulse.
        cycle(0, 8'h00, 0);
        for (int c = 1; c <= 4; c++) cycle(1, 8'h04, 0);
        check("pre-expiry enable", int'(enable), 1);
        cycle(1, 8'h04, 1);
        check("done+expiry enable", int'(enable), 0);
        check("done+expiry timeout", int'(timeout), 0);
`else
        for (int c = 2; c <= 22; c++) begin
            cycle(1, 8'h14, 0);
            check("long hold enable", int'(enable), 1);
            check("long hold select", int'(select), 2);
            check("long hold timeout", int'(timeout), 0);
        end
`endif

        // Randomized traffic against the reference model.
        cycle(0, 8'h00, 0);
        rq = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            rd = ($urandom_range(0, 4) == 0);
            rr = ($urandom_range(0, 99) != 0);
            cycle(rr, rq, rd);
            check("rand enable", int'(enable), (m_owner >= 0) ? 1 : 0);
            check("rand select", int'(select), m_sel);
            check("rand timeout", int'(timeout), m_tmo);
            check("rand decode", onehot(enable, select), (m_owner >= 0) ? (1 << m_owner) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_select_arbiter.md
Name: rr_select_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 3-to-8 enable decoder.
- Arbitrates up to 8 requesters and drives the decoder's `select[2:0]` and `enable` from registered outputs, so the decoder's one-hot output is the grant vector.
- Holds each grant until the requester signals done, drops its request, or (optionally) exceeds a hold limit. Rotates priority for fairness.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release (used only with the optional feature); legal range 2..255.
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  8  request vector, bit i = requester i
- done  input  1  current grant holder releases the grant
- select  output  3  index of granted requester, to decoder select
- enable  output  1  grant valid, to decoder enable
- timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset: `rst_n` is sampled low at a clk edge; asynchronous assertion has no effect until that edge.
  - Reset values: select=3'b000, enable=0, timeout=0, ptr=3'd0, hold counter=0, state=IDLE.
  - Reset mid-grant drops enable at that same edge, with no timeout pulse.
- Outputs are all registered. `select` is only meaningful while enable=1, but holds its last value while enable=0.
- ptr is an internal 3-bit priority pointer.
  - Search order is ptr, ptr+1, ..., ptr+7, mod 8.
  - On a grant to index i, ptr <= i+1 mod 8 (7 wraps to 0).
- State IDLE:
  - At an edge with req != 0: select <= first set bit in search order, enable <= 1, counter <= 0, go to GRANT.
  - Latency: req sampled high at edge k gives enable=1 after edge k (one cycle).
  - req == 0: remain in IDLE with enable=0.
- State GRANT, release condition:
  - Release = done=1, OR req[select]=0, OR (feature on) counter == MAX_HOLD-1.
  - On release: enable <= 0, go to IDLE.
  - At least one enable=0 cycle separates consecutive grants; this is a mandatory bubble so the decoder output returns to 8'h00 between owners.
- State GRANT, no release:
  - enable and select stay stable.
  - Counter increments (feature on), saturating at MAX_HOLD-1.
- Simultaneous events:
  - done together with req changes: done wins. Other requests are evaluated in IDLE on the next edge.
  - done and timeout in the same cycle: treated as normal release, timeout stays 0.
- `done` is ignored in IDLE.
- All 8 requesting continuously: grants go 0,1,2,...,7,0 with one idle cycle between each. No starvation; any requester waits at most 7 grants.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: RR_SELECT_ARBITER_TIMEOUT_EN.
- Defined:
  - Hold counter is compiled in.
  - A grant still active with counter == MAX_HOLD-1 releases at the next edge and pulses timeout=1 for exactly that one cycle, coincident with enable falling.
  - ptr has already advanced past the offender.
- Undefined:
  - Counter logic is absent and grants are held indefinitely until done or request drop.
  - timeout is tied to 0.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with req=8'hFF. Expect enable=0, select=0, timeout=0. Release reset with req=8'h00 and hold 5 cycles: enable stays 0.
- Single request: req=8'b0010_0000 sampled at edge k. Expect select=3'b101 and enable=1 after edge k. Pulse done at edge m: enable=0 after m, and the decoder output checks 8'b0010_0000 then 8'h00.
- Round-robin fairness: req=8'hFF held, done pulsed each grant cycle. Expect select sequence 0,1,...,7,0 with enable low one cycle between grants. ptr wraps 7->0.
- Priority skip/wrap: grant 6 then release; req=8'b0100_0001. Expect next grant select=0 (search 7,0), not 6.
- Request drop and simultaneous events: grant 3, then deassert req[3] without done. Expect enable=0 the next edge and no timeout. Separately, assert done with rst_n=0 mid-grant: outputs go to reset values.
- Timeout (macro defined, MAX_HOLD=4): grant 2 with req[2] held and done=0. Expect enable high for exactly 4 cycles, then timeout=1 for one cycle as enable falls, and next grant goes to another requester if one is pending. With macro undefined, the same stimulus holds enable for 20+ cycles and timeout stays 0.
